// File: rtl/shared_delay_scheduler_pkg.sv
// Shared types and helpers for the shared delay scheduler.
// The localparams give the default build configuration; the typedefs
// describe one pipeline entry at that configuration.
package shared_delay_scheduler_pkg;

    localparam int SDS_N   = 4;
    localparam int SDS_W   = 8;
    localparam int SDS_LAT = 2;
    localparam int SDS_IDW = $clog2(SDS_N);

    typedef logic [SDS_IDW-1:0] id_t;

    typedef struct packed {
        logic              valid;
        logic [SDS_W-1:0]  data;
        id_t               id;
    } stage_t;

    // Round-robin pointer after granting requester g: the slot just past
    // the winner, wrapping from n-1 back to 0. An out-of-range g leaves
    // the pointer where it was.
    function automatic int next_ptr(input int ptr, input int g, input int n);
        if (g < 0 || g >= n) begin
            return ptr;
        end
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/shared_delay_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward with
// wrap-around and grants the first active request (one-hot).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] gidx,
    output logic                 any
);

    localparam int IDW = $clog2(N);

    // First requester at or after ptr, in circular order, wins.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gidx       = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_delay_scheduler.sv
// Round-robin front end sharing one fixed-latency delay pipeline among
// N requesters. A stalled response freezes every stage, so the accept
// path and the pointer both hinge on the single advance signal.
module shared_delay_scheduler
    import shared_delay_scheduler_pkg::*;
#(
    parameter int N   = SDS_N,
    parameter int W   = SDS_W,
    parameter int LAT = SDS_LAT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req_valid,
    input  logic [N*W-1:0]       i_req_data,
    output logic [N-1:0]         o_req_ready,
    output logic                 o_resp_valid,
    output logic [W-1:0]         o_resp_data,
    output logic [$clog2(N)-1:0] o_resp_id,
    input  logic                 i_resp_ready,
    output logic                 o_busy
);

    localparam int IDW = $clog2(N);

    // Entry layout at this instance's N and W.
    typedef struct packed {
        logic            valid;
        logic [W-1:0]    data;
        logic [IDW-1:0]  id;
    } pipe_stage_t;

    pipe_stage_t     stage [LAT];
    logic [IDW-1:0]  ptr;
    logic [N-1:0]    grant;
    logic [IDW-1:0]  gidx;
    logic            any;
    logic            advance;
    logic            accept;
    logic [W-1:0]    gdata;

    rr_arbiter #(.N(N)) u_arb (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    // The head can only be replaced when it is empty or being consumed.
    assign advance     = !stage[LAT-1].valid || i_resp_ready;
    assign o_req_ready = advance ? grant : '0;
    assign accept      = advance && any;
    assign gdata       = i_req_data[int'(gidx)*W +: W];

    // Shift register of entries; everything holds while the head is stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage[i] <= '0;
            end
        end else if (advance) begin
            stage[0].valid <= accept;
            stage[0].data  <= accept ? gdata : '0;
            stage[0].id    <= accept ? gidx  : '0;
            for (int i = 1; i < LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Pointer moves just past the winner on every accept, holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= IDW'(next_ptr(int'(ptr), int'(gidx), N));
        end
    end

    assign o_resp_valid = stage[LAT-1].valid;
    assign o_resp_data  = stage[LAT-1].data;
    assign o_resp_id    = stage[LAT-1].id;

    // Busy whenever any stage carries a live entry.
    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            o_busy = o_busy | stage[i].valid;
        end
    end

endmodule

// File: tb/tb_shared_delay_scheduler.sv
// Directed bench for shared_delay_scheduler at N=4, W=8, LAT=2.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_shared_delay_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic        resp_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shared_delay_scheduler #(.N(4), .W(8), .LAT(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_resp_id    (resp_id),
        .i_resp_ready (resp_ready),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b1; req_valid = 4'b0; req_data = 32'h0; resp_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
        n_checks++; if (resp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", resp_data); end
        n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d exp 0", resp_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        @(negedge clk);
        req_data = {8'h00, 8'h5A, 8'h00, 8'h00}; req_valid = 4'b0100; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        @(negedge clk); req_valid = 4'b0; #1;
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_inflight got v=%b busy=%b exp v=0 busy=1", resp_valid, busy); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_data !== 8'h5A || resp_id !== 2'd2) begin
            n_fail++; $display("FAIL single_resp got v=%b d=%h id=%0d exp v=1 d=5a id=2", resp_valid, resp_data, resp_id); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drain got v=%b busy=%b exp 0 0", resp_valid, busy); end
    endtask

    task automatic test_fairness;
        logic [1:0] eid;
        @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = (i < 8) ? 4'hF : 4'h0; #1;
            n_checks++;
            if (req_ready !== ((i < 8) ? (4'b0001 << (i % 4)) : 4'b0000)) begin
                n_fail++; $display("FAIL fair_grant cycle %0d got %b", i, req_ready); end
            if (i >= 2) begin
                eid = 2'((i - 2) % 4);
                n_checks++;
                if (resp_valid !== 1'b1 || resp_id !== eid || resp_data !== (8'hA0 + 8'(eid))) begin
                    n_fail++; $display("FAIL fair_resp cycle %0d got v=%b id=%0d d=%h exp id=%0d", i, resp_valid, resp_id, resp_data, eid); end
            end else begin
                n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL fair_early cycle %0d got v=%b exp 0", i, resp_valid); end
            end
        end
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_drain busy got %b exp 0", busy); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        req_data = {8'h00, 8'h00, 8'h32, 8'h31}; req_valid = 4'b0011; resp_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_fill0 got %b exp 0001", req_ready); end
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_fill1 got %b exp 0010", req_ready); end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); resp_ready = 1'b0; #1;
            n_checks++;
            if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 8'h31) begin
                n_fail++; $display("FAIL bp_stall cycle %0d got rdy=%b v=%b id=%0d d=%h exp 0000 1 0 31", s, req_ready, resp_valid, resp_id, resp_data); end
        end
        @(negedge clk); resp_ready = 1'b1; req_data[7:0] = 8'h33; #1;
        n_checks++; if (req_ready !== 4'b0001 || resp_id !== 2'd0 || resp_data !== 8'h31) begin
            n_fail++; $display("FAIL bp_release got rdy=%b id=%0d d=%h exp 0001 0 31", req_ready, resp_id, resp_data); end
        @(negedge clk); req_valid = 4'b0; #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 8'h32) begin
            n_fail++; $display("FAIL bp_second got v=%b id=%0d d=%h exp 1 1 32", resp_valid, resp_id, resp_data); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 8'h33) begin
            n_fail++; $display("FAIL bp_next got v=%b id=%0d d=%h exp 1 0 33", resp_valid, resp_id, resp_data); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b busy=%b exp 0 0", resp_valid, busy); end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        req_data = {8'h73, 8'h00, 8'h00, 8'h70}; req_valid = 4'b1000; #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_acc3 got %b exp 1000", req_ready); end
        @(negedge clk); req_valid = 4'b0; #1;
        n_checks++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle1 got rdy=%b v=%b", req_ready, resp_valid); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== 8'h73) begin
            n_fail++; $display("FAIL wrap_resp3 got v=%b id=%0d d=%h exp 1 3 73", resp_valid, resp_id, resp_data); end
        @(negedge clk); req_valid = 4'b1001; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_first got %b exp 0001", req_ready); end
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_second got %b exp 1000", req_ready); end
        @(negedge clk); req_valid = 4'b0; #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 8'h70) begin
            n_fail++; $display("FAIL wrap_resp0 got v=%b id=%0d d=%h exp 1 0 70", resp_valid, resp_id, resp_data); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== 8'h73) begin
            n_fail++; $display("FAIL wrap_resp3b got v=%b id=%0d d=%h exp 1 3 73", resp_valid, resp_id, resp_data); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain got v=%b exp 0", resp_valid); end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        req_data = {8'h00, 8'h00, 8'h82, 8'h81}; req_valid = 4'b0011;
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_fill got %b exp 0010", req_ready); end
        @(negedge clk); req_valid = 4'b0; #1;
        n_checks++; if (busy !== 1'b1 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got busy=%b v=%b exp 1 1", busy, resp_valid); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async got v=%b busy=%b exp 0 0", resp_valid, busy); end
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_ghost cycle %0d got v=%b busy=%b", c, resp_valid, busy); end
        end
        @(negedge clk); req_data = {8'h94, 8'h93, 8'h92, 8'h91}; req_valid = 4'hF; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant got %b exp 0001", req_ready); end
        @(negedge clk); req_valid = 4'b0;
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 8'h91) begin
            n_fail++; $display("FAIL mid_after got v=%b id=%0d d=%h exp 1 0 91", resp_valid, resp_id, resp_data); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drain got v=%b exp 0", resp_valid); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_data = {8'h00, 8'hC2, 8'hC1, 8'hC0}; req_valid = 4'b0001; resp_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL b2b_fill0 got %b exp 0001", req_ready); end
        @(negedge clk); req_valid = 4'b0100; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL b2b_fill1 got %b exp 0100", req_ready); end
        @(negedge clk); req_valid = 4'b0010; #1;
        n_checks++; if (req_ready !== 4'b0010 || resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 8'hC0) begin
            n_fail++; $display("FAIL b2b_full got rdy=%b v=%b id=%0d d=%h exp 0010 1 0 c0", req_ready, resp_valid, resp_id, resp_data); end
        @(negedge clk); req_valid = 4'b0; #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 8'hC2) begin
            n_fail++; $display("FAIL b2b_resp2 got v=%b id=%0d d=%h exp 1 2 c2", resp_valid, resp_id, resp_data); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 8'hC1) begin
            n_fail++; $display("FAIL b2b_resp1 got v=%b id=%0d d=%h exp 1 1 c1", resp_valid, resp_id, resp_data); end
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got v=%b busy=%b exp 0 0", resp_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
